// File: rtl/nios2_qsys_oci_trace_pkg.sv
// Shared definitions for the Nios II OCI trace monitor.
//   state_t : monitor state encoding (IDLE=0, CAPTURE=1, DRAIN=2, DONE=3)
//   DROP_W  : width of the saturating dropped-frame counter
//   WCNT_W  : width of the wrapping accepted-frame counter
package nios2_qsys_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int DROP_W = 16;
  localparam int WCNT_W = 32;

endpackage

// File: rtl/nios2_qsys_oci_trace_fifo.sv
// Synchronous frame FIFO with a registered head stage.
//   clk, reset            : clock, synchronous active-high reset
//   flush                 : empties the FIFO on the next edge
//   push, push_data/count : write one frame (caller guarantees legality)
//   out_ready             : consumer accepts the head frame
//   out_data/count/valid  : registered head frame
//   pop                   : head accepted this cycle
//   full, level           : occupancy (level counts every stored frame)
module nios2_qsys_oci_trace_fifo #(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic [COUNT_W-1:0] push_count,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  output logic               pop,
  output logic               full,
  output logic [LVL_W-1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int W  = DATA_W + COUNT_W;

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   rd_next;

  // The extra pointer bit separates full (MSBs differ) from empty (equal).
  assign level   = LVL_W'(wr_ptr - rd_ptr);
  assign full    = (level == LVL_W'(DEPTH));
  assign pop     = out_valid && out_ready && !flush;
  assign rd_next = rd_ptr + (AW+1)'(pop);

  // NOTE: storage has no reset; only the pointers define what is valid, so
  // clearing the array would add reset fan-out for no functional gain.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {push_count, push_data};
    end
  end

  // The head is reloaded only from entries written on an earlier edge
  // (rd_next != wr_ptr before this cycle's push), so a fresh frame reaches
  // the head one edge after it is written and no write/read bypass exists.
  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge values, so pointer and head updates see a consistent state.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      rd_ptr <= rd_next;
      if (rd_next != wr_ptr) begin
        out_valid              <= 1'b1;
        {out_count, out_data}  <= mem[rd_next[AW-1:0]];
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/nios2_qsys_oci_trace_monitor.sv
// OCI trace monitor: captures packed trace frames into a FIFO, drains them
// over a ready/valid port, keeps drop/accept statistics and an XOR checksum,
// and sequences end-of-test.
//   clk, reset               : clock, synchronous active-high reset
//   capture_en               : arms capture from IDLE
//   dct_buffer/count/valid   : incoming trace frame (count 0 = empty frame)
//   test_ending, test_has_ended : end-of-test handshake
//   out_data/count/valid/ready  : drain port
//   fifo_level, overflow, drop_count, word_count, checksum : statistics
//   state, done              : monitor state and DONE flag
module nios2_qsys_oci_trace_monitor
  import nios2_qsys_oci_trace_pkg::*;
#(
  parameter int DATA_W  = 30,
  parameter int COUNT_W = 4,
  parameter int DEPTH   = 16,
  parameter int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               capture_en,
  input  logic [DATA_W-1:0]  dct_buffer,
  input  logic [COUNT_W-1:0] dct_count,
  input  logic               dct_valid,
  input  logic               test_ending,
  input  logic               test_has_ended,
  output logic [DATA_W-1:0]  out_data,
  output logic [COUNT_W-1:0] out_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LVL_W-1:0]   fifo_level,
  output logic               overflow,
  output logic [DROP_W-1:0]  drop_count,
  output logic [WCNT_W-1:0]  word_count,
  output logic [DATA_W-1:0]  checksum,
  output logic [1:0]         state,
  output logic               done
);

  state_t state_q;
  logic   accept;
  logic   push;
  logic   drop;
  logic   pop;
  logic   full;

  assign state  = state_q;
  assign accept = (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
  // A full FIFO still takes a frame when the head leaves in the same cycle.
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  nios2_qsys_oci_trace_fifo #(
    .DATA_W  (DATA_W),
    .COUNT_W (COUNT_W),
    .DEPTH   (DEPTH),
    .LVL_W   (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (state_q == ST_IDLE),
    .push       (push),
    .push_data  (dct_buffer),
    .push_count (dct_count),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_valid  (out_valid),
    .pop        (pop),
    .full       (full),
    .level      (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      done       <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
      word_count <= '0;
      checksum   <= '0;
    end else begin
      case (state_q)
        ST_IDLE:    if (capture_en) state_q <= ST_CAPTURE;
        ST_CAPTURE: if (test_ending || test_has_ended) state_q <= ST_DRAIN;
        ST_DRAIN: begin
          if ((fifo_level == '0) && test_has_ended) begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        default:    state_q <= ST_DONE;
      endcase

      if (push) begin
        word_count <= word_count + 1'b1;
        checksum   <= checksum ^ dct_buffer;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nios2_qsys_oci_trace_monitor.sv
// Scoreboard bench for nios2_qsys_oci_trace_monitor: stimulus pushes the
// expected frames, an independent monitor pops and compares on every
// out_valid && out_ready, and also checks head stability while stalled.
module tb_nios2_qsys_oci_trace_monitor;

  localparam int DATA_W  = 30;
  localparam int COUNT_W = 4;
  localparam int DEPTH   = 16;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               capture_en = 1'b0;
  logic [DATA_W-1:0]  dct_buffer = '0;
  logic [COUNT_W-1:0] dct_count = '0;
  logic               dct_valid = 1'b0;
  logic               test_ending = 1'b0;
  logic               test_has_ended = 1'b0;
  logic [DATA_W-1:0]  out_data;
  logic [COUNT_W-1:0] out_count;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [LVL_W-1:0]   fifo_level;
  logic               overflow;
  logic [15:0]        drop_count;
  logic [31:0]        word_count;
  logic [DATA_W-1:0]  checksum;
  logic [1:0]         state;
  logic               done;

  nios2_qsys_oci_trace_monitor #(
    .DATA_W (DATA_W), .COUNT_W (COUNT_W), .DEPTH (DEPTH), .LVL_W (LVL_W)
  ) dut (
    .clk (clk), .reset (reset), .capture_en (capture_en),
    .dct_buffer (dct_buffer), .dct_count (dct_count), .dct_valid (dct_valid),
    .test_ending (test_ending), .test_has_ended (test_has_ended),
    .out_data (out_data), .out_count (out_count), .out_valid (out_valid),
    .out_ready (out_ready), .fifo_level (fifo_level), .overflow (overflow),
    .drop_count (drop_count), .word_count (word_count), .checksum (checksum),
    .state (state), .done (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [COUNT_W+DATA_W-1:0] exp_q[$];
  logic [31:0]               exp_words = 0;
  logic [DATA_W-1:0]         exp_sum = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] data, input logic [COUNT_W-1:0] cnt,
                            input bit kept);
    dct_buffer = data;
    dct_count  = cnt;
    dct_valid  = 1'b1;
    if (kept) begin
      exp_q.push_back({cnt, data});
      exp_words = exp_words + 1;
      exp_sum   = exp_sum ^ data;
    end
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_out_valid"},  64'(out_valid),  64'd0);
    check({tag, "_out_data"},   64'(out_data),   64'd0);
    check({tag, "_out_count"},  64'(out_count),  64'd0);
    check({tag, "_fifo_level"}, 64'(fifo_level), 64'd0);
    check({tag, "_overflow"},   64'(overflow),   64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    check({tag, "_word_count"}, 64'(word_count), 64'd0);
    check({tag, "_checksum"},   64'(checksum),   64'd0);
    check({tag, "_state"},      64'(state),      64'd0);
    check({tag, "_done"},       64'(done),       64'd0);
  endtask

  task automatic start_capture();
    capture_en = 1'b1;
    tick();
    capture_en = 1'b0;
    check("capture_state", 64'(state), 64'd1);
  endtask

  // Monitor: compares each delivered head against the scoreboard and checks
  // that a stalled head does not change.
  logic                      held_valid = 1'b0;
  logic [COUNT_W+DATA_W-1:0] held;

  always @(negedge clk) begin
    if (reset) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid && out_valid) check("stall_stable", 64'({out_count, out_data}), 64'(held));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 64'({out_count, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check("frame", 64'({out_count, out_data}), 64'(exp_q.pop_front()));
        end
        held_valid = 1'b0;
      end else if (out_valid) begin
        held_valid = 1'b1;
        held       = {out_count, out_data};
      end else begin
        held_valid = 1'b0;
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    check_reset_values("rst");

    // Basic capture of three frames.
    start_capture();
    out_ready = 1'b1;
    send_frame(30'h1, 4'd5, 1'b1);
    send_frame(30'h2, 4'd5, 1'b1);
    send_frame(30'h4, 4'd5, 1'b1);
    wait_drain(50);
    check("basic_word_count", 64'(word_count), 64'd3);
    check("basic_checksum",   64'(checksum),   64'h7);
    check("basic_overflow",   64'(overflow),   64'd0);

    // Overflow: DEPTH+2 frames with the consumer stalled.
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      send_frame(30'h100 + 30'(i), 4'd1 + 4'(i % 15), (i < DEPTH));
    end
    check("ovf_level",      64'(fifo_level), 64'd16);
    check("ovf_overflow",   64'(overflow),   64'd1);
    check("ovf_drop_count", 64'(drop_count), 64'd2);
    // Full FIFO with simultaneous push and pop: push accepted, level holds.
    out_ready = 1'b1;
    send_frame(30'h3AA, 4'd9, 1'b1);
    out_ready = 1'b0;
    check("fullpp_level",      64'(fifo_level), 64'd16);
    check("fullpp_drop_count", 64'(drop_count), 64'd2);
    check("fullpp_word_count", 64'(word_count), 64'd20);
    out_ready = 1'b1;
    wait_drain(100);

    // Zero-count frames are ignored entirely.
    send_frame(30'h11, 4'd3, 1'b1);
    send_frame(30'h22, 4'd0, 1'b0);
    send_frame(30'h33, 4'd1, 1'b1);
    send_frame(30'h44, 4'd0, 1'b0);
    send_frame(30'h55, 4'd15, 1'b1);
    wait_drain(50);
    check("zero_word_count", 64'(word_count), 64'(exp_words));
    check("zero_word_abs",   64'(word_count), 64'd23);
    check("zero_drop_count", 64'(drop_count), 64'd2);
    check("zero_checksum",   64'(checksum),   64'(exp_sum));

    // End of test: four queued, fifth presented with test_ending.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_frame(30'h200 + 30'(i), 4'd2, 1'b1);
    test_ending = 1'b1;
    send_frame(30'h2FF, 4'd7, 1'b1);
    test_ending = 1'b0;
    check("end_state_drain", 64'(state), 64'd2);
    test_has_ended = 1'b1;
    tick();
    check("end_early_state", 64'(state),      64'd2);
    check("end_level",       64'(fifo_level), 64'd5);
    send_frame(30'h3FF, 4'd4, 1'b0);
    check("end_ignored_words", 64'(word_count), 64'd28);
    check("end_ignored_drops", 64'(drop_count), 64'd2);
    out_ready = 1'b1;
    wait_drain(50);
    check("end_last_pop_state", 64'(state),      64'd2);
    check("end_last_pop_done",  64'(done),       64'd0);
    check("end_last_pop_level", 64'(fifo_level), 64'd0);
    tick();
    check("end_done_state", 64'(state), 64'd3);
    check("end_done",       64'(done),  64'd1);
    test_has_ended = 1'b0;
    tick();
    check("end_done_hold", 64'(state), 64'd3);

    // Reset in DRAIN with five frames queued.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_words = 0;
    exp_sum   = '0;
    start_capture();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(30'h400 + 30'(i), 4'd3, 1'b1);
    test_ending = 1'b1;
    tick();
    test_ending = 1'b0;
    check("rstdrain_state", 64'(state),      64'd2);
    check("rstdrain_level", 64'(fifo_level), 64'd5);
    exp_q.delete();
    exp_words = 0;
    exp_sum   = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_values("rstdrain");

    // Random consumer back-pressure.
    start_capture();
    fork
      begin
        repeat (80) begin
          out_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          send_frame(30'h1000 * 30'(i + 1) + 30'h5, 4'd1 + 4'(i % 15), 1'b1);
          tick();
        end
      end
    join
    out_ready = 1'b1;
    wait_drain(100);
    check("rand_word_count", 64'(word_count), 64'd20);
    check("rand_checksum",   64'(checksum),   64'(exp_sum));
    check("rand_drop_count", 64'(drop_count), 64'd0);
    check("rand_overflow",   64'(overflow),   64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_qsys_oci_trace_monitor.md
# nios2_qsys_oci_trace_monitor

Parametrised simulation and debug monitor for the Nios II OCI trace path. It accepts packed trace frames (`dct_buffer`/`dct_count`) from the OCI and buffers them in a FIFO. It drains them through a ready/valid port and keeps capture statistics and a running checksum. It sequences end-of-test via `test_ending`/`test_has_ended`. It sits beside the OCI block and feeds either a testbench scoreboard or an on-chip debug reader.

## Interface
- DATA_W, 30: trace frame width.
- COUNT_W, 4: width of the valid-slot count accompanying each frame.
- DEPTH, 16: FIFO depth in frames; power of two, ≥2.
- LVL_W, $clog2(DEPTH)+1: FIFO level width (derived).
- clk  in  1  single clock; every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high.
- capture_en  in  1  arms capture from IDLE.
- dct_buffer  in  DATA_W  trace frame.
- dct_count  in  COUNT_W  number of valid slots in the frame; 0 = empty frame.
- dct_valid  in  1  frame present this cycle.
- test_ending  in  1  stop-capture request.
- test_has_ended  in  1  test finished.
- out_data  out  DATA_W  head frame.
- out_count  out  COUNT_W  head frame count.
- out_valid  out  1  head valid.
- out_ready  in  1  consumer accepts head.
- fifo_level  out  LVL_W  frames stored.
- overflow  out  1  sticky; set when any frame is dropped.
- drop_count  out  16  dropped frames; saturates at 0xFFFF.
- word_count  out  32  accepted frames; wraps.
- checksum  out  DATA_W  XOR of all accepted frames.
- state  out  2  IDLE=0, CAPTURE=1, DRAIN=2, DONE=3.
- done  out  1  high only in DONE.

## Operation
- A frame is accepted when all three hold: state is CAPTURE, `dct_valid`=1, and `dct_count`≠0. Frames with count 0 are ignored. They are neither dropped nor counted.
- A push is legal if the FIFO is not full, or if a pop occurs in the same cycle (`out_valid`&&`out_ready`).
- If the FIFO is full and no pop occurs, the frame is dropped: `overflow` is set and `drop_count` increments, saturating.
- An accepted frame increments `word_count` and updates `checksum ^= dct_buffer`.
- The pop side runs in every state except IDLE; IDLE always holds the FIFO empty.
- State transitions:
  - IDLE→CAPTURE when `capture_en`=1.
  - CAPTURE→DRAIN when `test_ending` or `test_has_ended` is 1. A frame presented in that same cycle is still accepted.
  - DRAIN→DONE when the FIFO is empty and `test_has_ended` is 1. Both conditions may arrive in either order.
  - DONE holds until `reset`.
- In DRAIN and DONE, `dct_valid` is ignored. Ignored frames are not counted as drops.
- `test_ending` in IDLE is ignored.

## Timing
- Reset values: FIFO empty, `out_valid`=0, `out_data`=0, `out_count`=0, `fifo_level`=0, `overflow`=0, `drop_count`=0, `word_count`=0, `checksum`=0, `state`=IDLE, `done`=0.
- Reset asserted mid-operation discards FIFO contents on the next edge. No partial drain occurs.
- Latency: a frame accepted at edge N appears on `out_valid`/`out_data` after edge N+1 when the FIFO was empty.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_count` hold stable.
- `out_valid` never drops without a pop, except on reset.
- `fifo_level`, counters, `checksum` and `overflow` update on the edge of the accepting or dropping cycle and are visible the next cycle.
- `state` and `done` are registered; `done` rises one cycle after the DRAIN exit condition is met.
- Pointers wrap modulo DEPTH. Full is distinguished from empty using the extra pointer bit.

## Structure
- Package `nios2_qsys_oci_trace_pkg`: state encoding constants (IDLE/CAPTURE/DRAIN/DONE), DROP_W=16, WCNT_W=32.
- Sub-module `nios2_qsys_oci_trace_fifo`: synchronous FIFO, DEPTH×(DATA_W+COUNT_W), with registered head and a level output.
- The top level holds the state machine, the counters and the checksum.

## Test plan
- Reset, then `capture_en` with 3 frames (0x1, 0x2, 0x4, count 5), `out_ready`=1 → outputs in order; `word_count`=3, `checksum`=0x7, `overflow`=0.
- `out_ready`=0, push DEPTH+2 frames → `fifo_level`=16, `overflow`=1, `drop_count`=2. Then full plus simultaneous push/pop → push accepted, level stays 16.
- Frames with `dct_count`=0 interleaved with valid frames → only the non-zero frames are counted; `drop_count` unchanged.
- Frame presented with `test_ending`, 4 frames queued, `test_has_ended` asserted early → the frame is captured; DONE only after the 5th pop; `done` one cycle later.
- `reset` pulsed in DRAIN with 5 frames queued → all outputs at reset values the next cycle, `state`=IDLE.
- `out_ready` toggled randomly → `out_data` stable while stalled and every frame delivered exactly once.
